// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_arb_pkg
// Description : Shared types, default sizes and length clamp for the TX FIFO
//               write-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

  localparam int C_DATA_WIDTH = 8;
  localparam int C_NUM_REQ    = 2;
  localparam int C_MAX_BYTES  = 2;
  localparam int C_LEN_W      = 2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // Zero-length frames still carry one byte; oversize frames are truncated.
  function automatic int clamp_len(input int len, input int max_bytes);
    if (len == 0) return 1;
    if (len > max_bytes) return max_bytes;
    return len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational rotating-mask priority picker. Requesters at or
//               above i_ptr win first, otherwise the search wraps to index 0.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx
);

  logic [NUM_REQ-1:0] w_mask;
  logic [NUM_REQ-1:0] w_hi;
  logic [NUM_REQ-1:0] w_pick;
  logic               w_found;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_mask[i] = (i >= int'(i_ptr));
    end
    w_hi    = i_req & w_mask;
    w_pick  = (|w_hi) ? w_hi : i_req;
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick[i] && !w_found) begin
        o_gnt[i] = 1'b1;
        o_idx    = IDX_W'(i);
        w_found  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Round-robin arbiter that serialises atomic multi-byte frames
//               from several requesters into one FIFO write port, LSB first.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = C_DATA_WIDTH,
  parameter int NUM_REQ    = C_NUM_REQ,
  parameter int MAX_BYTES  = C_MAX_BYTES,
  parameter int LEN_W      = C_LEN_W
) (
  input  logic                                  CLK,
  input  logic                                  RST,
  input  logic [NUM_REQ-1:0]                    REQ,
  input  logic [NUM_REQ*MAX_BYTES*DATA_WIDTH-1:0] REQ_DATA,
  input  logic [NUM_REQ*LEN_W-1:0]              REQ_LEN,
  input  logic                                  FULL,
  output logic [DATA_WIDTH-1:0]                 WR_DATA,
  output logic                                  W_INC,
  output logic [NUM_REQ-1:0]                    GNT,
  output logic [NUM_REQ-1:0]                    DONE,
  output logic                                  BUSY
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int FRAME_W = MAX_BYTES * DATA_WIDTH;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     sel_q, sel_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   done_q, done_d;

  logic [NUM_REQ-1:0]   w_arb_gnt;
  logic [IDX_W-1:0]     w_arb_idx;
  logic [DATA_WIDTH-1:0] w_byte;
  logic                 w_last;

  // ptr_q is the first index searched, i.e. one past the last winner.
  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .i_req (REQ),
    .i_ptr (ptr_q),
    .o_gnt (w_arb_gnt),
    .o_idx (w_arb_idx)
  );

  always_comb begin
    w_byte = '0;
    for (int k = 0; k < MAX_BYTES; k++) begin
      if (int'(cnt_q) == k) w_byte = frame_q[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign W_INC   = (state_q == ST_SEND) && !FULL;
  assign WR_DATA = (state_q == ST_SEND) ? w_byte : '0;
  assign w_last  = W_INC && (cnt_q == len_q - LEN_W'(1));
  assign GNT     = gnt_q;
  assign DONE    = done_q;
  assign BUSY    = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    frame_d = frame_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    gnt_d   = '0;
    done_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (|REQ) begin
          state_d = ST_SEND;
          sel_d   = w_arb_idx;
          ptr_d   = IDX_W'((int'(w_arb_idx) + 1) % NUM_REQ);
          cnt_d   = '0;
          gnt_d   = w_arb_gnt;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (int'(w_arb_idx) == i) begin
              frame_d = REQ_DATA[i*FRAME_W +: FRAME_W];
              len_d   = LEN_W'(clamp_len(int'(REQ_LEN[i*LEN_W +: LEN_W]), MAX_BYTES));
            end
          end
        end
      end
      ST_SEND: begin
        if (W_INC) begin
          cnt_d = cnt_q + LEN_W'(1);
          if (w_last) begin
            state_d = ST_IDLE;
            done_d  = NUM_REQ'(1) << sel_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      frame_q <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      frame_q <= frame_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_arbiter
// Description : Self-checking bench for fifo_wr_arbiter: directed scenarios
//               plus randomized traffic against a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

  localparam int DW = 8;
  localparam int NR = 2;
  localparam int MB = 2;
  localparam int LW = 2;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic [NR-1:0]    REQ = '0;
  logic [NR*MB*DW-1:0] REQ_DATA = '0;
  logic [NR*LW-1:0] REQ_LEN = '0;
  logic             FULL = 1'b0;
  logic [DW-1:0]    WR_DATA;
  logic             W_INC;
  logic [NR-1:0]    GNT;
  logic [NR-1:0]    DONE;
  logic             BUSY;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  fifo_wr_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR),
    .MAX_BYTES  (MB),
    .LEN_W      (LW)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .REQ      (REQ),
    .REQ_DATA (REQ_DATA),
    .REQ_LEN  (REQ_LEN),
    .FULL     (FULL),
    .WR_DATA  (WR_DATA),
    .W_INC    (W_INC),
    .GNT      (GNT),
    .DONE     (DONE),
    .BUSY     (BUSY)
  );

  task automatic do_reset();
    @(posedge CLK); #1;
    RST = 1'b1; REQ = '0; FULL = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; REQ = '1; REQ_LEN = '1; REQ_DATA = $urandom; FULL = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++; if (GNT !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b expected 00", GNT); end
    checks++; if (DONE !== 2'b00) begin errors++; $display("FAIL reset_done: got %b expected 00", DONE); end
    checks++; if (W_INC !== 1'b0) begin errors++; $display("FAIL reset_winc: got %b expected 0", W_INC); end
    checks++; if (WR_DATA !== 8'h00) begin errors++; $display("FAIL reset_wrdata: got %h expected 00", WR_DATA); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
    @(posedge CLK); #1;
    RST = 1'b0; REQ = '0;
    @(negedge CLK);
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b expected 0", BUSY); end
  endtask

  task automatic test_single_frame();
    logic [1:0] e_gnt  [5] = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
    logic [1:0] e_done [5] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
    logic [7:0] e_wr   [5] = '{8'h00, 8'hEF, 8'hBE, 8'h00, 8'h00};
    logic [4:0] e_winc = 5'b00110;
    logic [4:0] e_busy = 5'b00110;
    for (int c = 0; c < 5; c++) begin
      @(posedge CLK); #1;
      REQ = (c == 0) ? 2'b01 : 2'b00;
      if (c == 0) begin REQ_DATA = 32'h0000_BEEF; REQ_LEN = 4'b0010; end
      @(negedge CLK);
      checks++; if (GNT !== e_gnt[c]) begin errors++; $display("FAIL single_gnt c%0d: got %b expected %b", c, GNT, e_gnt[c]); end
      checks++; if (DONE !== e_done[c]) begin errors++; $display("FAIL single_done c%0d: got %b expected %b", c, DONE, e_done[c]); end
      checks++; if (W_INC !== e_winc[c]) begin errors++; $display("FAIL single_winc c%0d: got %b expected %b", c, W_INC, e_winc[c]); end
      checks++; if (BUSY !== e_busy[c]) begin errors++; $display("FAIL single_busy c%0d: got %b expected %b", c, BUSY, e_busy[c]); end
      if (e_winc[c]) begin
        checks++; if (WR_DATA !== e_wr[c]) begin errors++; $display("FAIL single_wrdata c%0d: got %h expected %h", c, WR_DATA, e_wr[c]); end
      end
    end
  endtask

  task automatic test_contention();
    logic [1:0] gq [$];
    logic [7:0] bq [$];
    logic [1:0] eg;
    logic [7:0] eb;
    int c = 0;
    do_reset();
    REQ_DATA = 32'h00B1_00A0;
    REQ_LEN  = 4'b0101;
    while ((gq.size() < 4 || BUSY) && c < 40) begin
      @(posedge CLK); #1;
      REQ = (gq.size() < 4) ? 2'b11 : 2'b00;
      @(negedge CLK);
      if (GNT !== 2'b00) gq.push_back(GNT);
      if (W_INC) bq.push_back(WR_DATA);
      checks++; if (GNT !== 2'b00 && DONE !== 2'b00) begin errors++; $display("FAIL contention_overlap c%0d: got GNT=%b DONE=%b expected no overlap", c, GNT, DONE); end
      c++;
    end
    checks++; if (gq.size() != 4) begin errors++; $display("FAIL contention_grant_count: got %0d expected 4", gq.size()); end
    checks++; if (bq.size() != 4) begin errors++; $display("FAIL contention_write_count: got %0d expected 4", bq.size()); end
    for (int i = 0; i < 4; i++) begin
      eg = (i % 2 == 0) ? 2'b01 : 2'b10;
      eb = (i % 2 == 0) ? 8'hA0 : 8'hB1;
      if (i < gq.size()) begin
        checks++; if (gq[i] !== eg) begin errors++; $display("FAIL contention_grant%0d: got %b expected %b", i, gq[i], eg); end
      end
      if (i < bq.size()) begin
        checks++; if (bq[i] !== eb) begin errors++; $display("FAIL contention_byte%0d: got %h expected %h", i, bq[i], eb); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] e_gnt  [8] = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    logic [1:0] e_done [8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
    logic [7:0] e_wr   [8] = '{8'h00, 8'h34, 8'h12, 8'h12, 8'h12, 8'h12, 8'h00, 8'h00};
    logic [7:0] full_v = 8'b00011100;
    logic [7:0] e_winc = 8'b00100010;
    logic [7:0] e_busy = 8'b00111110;
    for (int c = 0; c < 8; c++) begin
      @(posedge CLK); #1;
      REQ  = (c == 0) ? 2'b01 : 2'b00;
      FULL = full_v[c];
      if (c == 0) begin REQ_DATA = 32'h0000_1234; REQ_LEN = 4'b0010; end
      @(negedge CLK);
      checks++; if (GNT !== e_gnt[c]) begin errors++; $display("FAIL bp_gnt c%0d: got %b expected %b", c, GNT, e_gnt[c]); end
      checks++; if (DONE !== e_done[c]) begin errors++; $display("FAIL bp_done c%0d: got %b expected %b", c, DONE, e_done[c]); end
      checks++; if (W_INC !== e_winc[c]) begin errors++; $display("FAIL bp_winc c%0d: got %b expected %b", c, W_INC, e_winc[c]); end
      checks++; if (BUSY !== e_busy[c]) begin errors++; $display("FAIL bp_busy c%0d: got %b expected %b", c, BUSY, e_busy[c]); end
      if (e_busy[c]) begin
        checks++; if (WR_DATA !== e_wr[c]) begin errors++; $display("FAIL bp_wrdata c%0d: got %h expected %h", c, WR_DATA, e_wr[c]); end
      end
    end
    FULL = 1'b0;
  endtask

  task automatic test_len_clamp();
    logic [7:0] got [$];
    int n_wr;
    int n_done;
    int exp_wr;
    for (int t = 0; t < 2; t++) begin
      n_wr = 0; n_done = 0; got.delete();
      exp_wr = (t == 0) ? 1 : 2;
      for (int c = 0; c < 8; c++) begin
        @(posedge CLK); #1;
        if (c == 0) begin
          REQ      = (t == 0) ? 2'b01 : 2'b10;
          REQ_DATA = 32'hE5D4_77C3;
          REQ_LEN  = (t == 0) ? 4'b0000 : 4'b1100;
        end else begin
          REQ = 2'b00;
        end
        @(negedge CLK);
        if (W_INC) begin n_wr++; got.push_back(WR_DATA); end
        if (DONE !== 2'b00) n_done++;
      end
      checks++; if (n_wr != exp_wr) begin errors++; $display("FAIL clamp_writes t%0d: got %0d expected %0d", t, n_wr, exp_wr); end
      checks++; if (n_done != 1) begin errors++; $display("FAIL clamp_done t%0d: got %0d expected 1", t, n_done); end
      if (got.size() >= 1) begin
        checks++;
        if (got[0] !== ((t == 0) ? 8'hC3 : 8'hD4)) begin errors++; $display("FAIL clamp_byte0 t%0d: got %h expected %h", t, got[0], (t == 0) ? 8'hC3 : 8'hD4); end
      end
      if (t == 1 && got.size() >= 2) begin
        checks++; if (got[1] !== 8'hE5) begin errors++; $display("FAIL clamp_byte1: got %h expected e5", got[1]); end
      end
    end
  endtask

  task automatic test_data_capture();
    logic [7:0] got [$];
    int saw_gnt = 0;
    int saw_done = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge CLK); #1;
      if (c == 0) begin
        REQ = 2'b10; REQ_DATA = 32'h5A6B_0000; REQ_LEN = 4'b1000;
      end else begin
        REQ = 2'b00; REQ_DATA = $urandom;
      end
      @(negedge CLK);
      if (W_INC) got.push_back(WR_DATA);
      if (GNT === 2'b10) saw_gnt++;
      if (DONE === 2'b10) saw_done++;
    end
    checks++; if (saw_gnt != 1) begin errors++; $display("FAIL capture_gnt: got %0d grants expected 1", saw_gnt); end
    checks++; if (saw_done != 1) begin errors++; $display("FAIL capture_done: got %0d dones expected 1", saw_done); end
    checks++; if (got.size() != 2) begin errors++; $display("FAIL capture_count: got %0d expected 2", got.size()); end
    if (got.size() == 2) begin
      checks++; if (got[0] !== 8'h6B || got[1] !== 8'h5A) begin errors++; $display("FAIL capture_bytes: got %h %h expected 6b 5a", got[0], got[1]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [1:0] req_v  [7] = '{2'b01, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
    logic [1:0] e_gnt  [7] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
    logic [1:0] e_done [7] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
    logic [7:0] e_wr   [7] = '{8'h00, 8'h11, 8'h00, 8'h11, 8'h22, 8'h00, 8'h00};
    logic [6:0] e_winc = 7'b0011010;
    logic [6:0] e_busy = 7'b0011010;
    for (int c = 0; c < 7; c++) begin
      @(posedge CLK); #1;
      REQ = req_v[c];
      RST = (c == 1);
      if (c == 0) begin REQ_DATA = 32'h4433_2211; REQ_LEN = 4'b1010; end
      @(negedge CLK);
      checks++; if (GNT !== e_gnt[c]) begin errors++; $display("FAIL midrst_gnt c%0d: got %b expected %b", c, GNT, e_gnt[c]); end
      checks++; if (DONE !== e_done[c]) begin errors++; $display("FAIL midrst_done c%0d: got %b expected %b", c, DONE, e_done[c]); end
      checks++; if (W_INC !== e_winc[c]) begin errors++; $display("FAIL midrst_winc c%0d: got %b expected %b", c, W_INC, e_winc[c]); end
      checks++; if (BUSY !== e_busy[c]) begin errors++; $display("FAIL midrst_busy c%0d: got %b expected %b", c, BUSY, e_busy[c]); end
      if (e_winc[c]) begin
        checks++; if (WR_DATA !== e_wr[c]) begin errors++; $display("FAIL midrst_wrdata c%0d: got %h expected %h", c, WR_DATA, e_wr[c]); end
      end
    end
    RST = 1'b0;
  endtask

  // Frame-level model: rotating search over requesters, byte queue per frame.
  task automatic test_random();
    int          ptr_m = 0;
    int          sel_m = 0;
    int          w;
    int          ln;
    bit          act = 1'b0;
    bit          prev_idle = 1'b1;
    logic [NR-1:0]       prev_req = '0;
    logic [NR*MB*DW-1:0] prev_data = '0;
    logic [NR*LW-1:0]    prev_len = '0;
    logic [NR-1:0]       done_pend = '0;
    logic [NR-1:0]       e_gnt;
    logic [NR-1:0]       e_done;
    logic [DW-1:0]       exp_q [$];
    do_reset();
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(posedge CLK); #1;
      REQ      = ($urandom_range(0, 3) == 0) ? 2'b00 : NR'($urandom);
      REQ_DATA = $urandom;
      REQ_LEN  = 4'($urandom);
      FULL     = ($urandom_range(0, 3) == 0);
      @(negedge CLK);
      e_gnt  = '0;
      e_done = done_pend;
      done_pend = '0;
      if (prev_idle && prev_req != '0) begin
        w = -1;
        for (int k = 0; k < NR; k++) begin
          int i;
          i = (ptr_m + k) % NR;
          if (w < 0 && prev_req[i]) w = i;
        end
        e_gnt[w] = 1'b1;
        sel_m = w;
        ptr_m = (w + 1) % NR;
        act   = 1'b1;
        ln    = int'(prev_len[w*LW +: LW]);
        if (ln == 0) ln = 1;
        if (ln > MB) ln = MB;
        exp_q.delete();
        for (int k = 0; k < ln; k++) exp_q.push_back(prev_data[w*MB*DW + k*DW +: DW]);
      end
      prev_idle = !act;
      checks++; if (GNT !== e_gnt) begin errors++; $display("FAIL rand_gnt cyc%0d: got %b expected %b", cyc, GNT, e_gnt); end
      checks++; if (DONE !== e_done) begin errors++; $display("FAIL rand_done cyc%0d: got %b expected %b", cyc, DONE, e_done); end
      checks++; if (BUSY !== act) begin errors++; $display("FAIL rand_busy cyc%0d: got %b expected %b", cyc, BUSY, act); end
      checks++; if (W_INC !== (act && !FULL)) begin errors++; $display("FAIL rand_winc cyc%0d: got %b expected %b", cyc, W_INC, act && !FULL); end
      if (act && exp_q.size() > 0) begin
        checks++; if (WR_DATA !== exp_q[0]) begin errors++; $display("FAIL rand_wrdata cyc%0d: got %h expected %h", cyc, WR_DATA, exp_q[0]); end
        if (!FULL) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) begin
            act = 1'b0;
            done_pend = NR'(1) << sel_m;
          end
        end
      end
      prev_req  = REQ;
      prev_data = REQ_DATA;
      prev_len  = REQ_LEN;
    end
    @(posedge CLK); #1;
    REQ = '0; FULL = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_contention();
    test_backpressure();
    test_len_clamp();
    test_data_capture();
    test_reset_mid_frame();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
